// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
// ----------------
// Writeback scheduler for a 16-entry, single-write-port register file with x0
// hardwired to zero. NUM_SRC writeback producers (ALU, load unit, CSR/mul)
// share the one write port through a round-robin arbiter. The winner is
// registered into a one-stage output that drives the register file write port.
// A pending-write scoreboard lets the issue stage detect RAW/WAW hazards.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   src_valid / src_ready    per-source write request / grant (one-hot or zero)
//   src_rd, src_data         packed per-source destination index and write data
//                            (source i at [i*REG_AW +: REG_AW] / [i*XLEN +: XLEN])
//   rf_we, rf_rd, rf_rd_data register file write port, one cycle after grant
//   issue_valid, issue_rd    issue stage allocating a destination register
//   issue_ready              allocation accepted (destination not pending)
//   pend_mask                bit r set = a write to register r is outstanding
//   wb_err                   sticky orphan-write flag
//
// Optional feature
//   RF_WB_ORPHAN_CHECK_EN    when defined, wb_err latches high after a write to
//                            a non-zero register that had no pending allocation.
//                            When undefined, wb_err is tied low.

module regfile_wb_sched #(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = 32,
  parameter int REG_AW  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*REG_AW-1:0] src_rd,
  input  logic [NUM_SRC*XLEN-1:0]   src_data,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_rd,
  output logic [XLEN-1:0]           rf_rd_data,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  output logic                      issue_ready,
  output logic [2**REG_AW-1:0]      pend_mask,
  output logic                      wb_err
);

  localparam int NREG  = 2**REG_AW;
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              xfer;
  logic [PTR_W:0]    cand;
  logic [REG_AW-1:0] gnt_rd;
  logic [XLEN-1:0]   gnt_data;
  logic              we_q;
  logic [NREG-1:0]   pend_q;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;

  // Round-robin search: walk the sources starting at rr_ptr, wrapping modulo
  // NUM_SRC (which need not be a power of two), and pick the first valid one.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_SRC)) begin
        cand = cand - (PTR_W+1)'(NUM_SRC);
      end
      if (!gnt_any && src_valid[cand[PTR_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[PTR_W-1:0];
      end
    end
  end

  // Grants are suppressed while reset is asserted so nothing is accepted
  // during the reset cycle.
  assign xfer = gnt_any & rst_n;

  always_comb begin
    src_ready = '0;
    gnt_rd    = '0;
    gnt_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        src_ready[i] = xfer;
        gnt_rd       = src_rd[i*REG_AW +: REG_AW];
        gnt_data     = src_data[i*XLEN +: XLEN];
      end
    end
  end

  // The pointer moves just past the source that was served; idle cycles
  // leave it where it is.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      if (gnt_idx == PTR_W'(NUM_SRC-1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= gnt_idx + PTR_W'(1);
      end
    end
  end

  // Output stage. Index and data are captured on every transfer (x0 included)
  // and held otherwise; the write enable only fires for non-zero destinations.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      rf_rd      <= '0;
      rf_rd_data <= '0;
    end else begin
      we_q <= xfer && (gnt_rd != '0);
      if (xfer) begin
        rf_rd      <= gnt_rd;
        rf_rd_data <= gnt_data;
      end
    end
  end

  // Gating with rst_n kills a write that was already registered when reset
  // arrives, so nothing commits during the reset cycle itself.
  assign rf_we = we_q & rst_n;

  // Scoreboard. issue_ready looks only at the registered mask, so a register
  // whose write commits this cycle still reads busy.
  assign issue_ready = rst_n && ((issue_rd == '0) || !pend_q[issue_rd]);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && issue_ready && (issue_rd != '0)) begin
      set_vec[issue_rd] = 1'b1;
    end
    if (we_q) begin
      clr_vec[rf_rd] = 1'b1;
    end
  end

  // Clear is applied before set so a coinciding issue of the same register
  // keeps the bit high; bit 0 is forced low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= ((pend_q & ~clr_vec) | set_vec) & {{(NREG-1){1'b1}}, 1'b0};
    end
  end

  assign pend_mask = pend_q;

`ifdef RF_WB_ORPHAN_CHECK_EN
  logic err_q;

  // A write to a register nobody allocated points at a broken issue/writeback
  // pairing; remember it until the next reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (xfer && (gnt_rd != '0) && !pend_q[gnt_rd]) begin
      err_q <= 1'b1;
    end
  end

  assign wb_err = err_q;
`else
  assign wb_err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched
// -------------------
// Self-checking bench for regfile_wb_sched. A behavioural model tracks the
// expected pointer, scoreboard and write port; a compare process checks every
// DUT output against it on each falling edge. Directed sequences add literal
// expectations at the interesting points.

module tb_regfile_wb_sched;

  localparam int NUM_SRC = 3;
  localparam int XLEN    = 32;
  localparam int REG_AW  = 4;
  localparam int NREG    = 16;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*REG_AW-1:0] src_rd;
  logic [NUM_SRC*XLEN-1:0]   src_data;
  logic                      rf_we;
  logic [REG_AW-1:0]         rf_rd;
  logic [XLEN-1:0]           rf_rd_data;
  logic                      issue_valid;
  logic [REG_AW-1:0]         issue_rd;
  logic                      issue_ready;
  logic [NREG-1:0]           pend_mask;
  logic                      wb_err;

  regfile_wb_sched #(
    .NUM_SRC(NUM_SRC),
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_rd     (src_rd),
    .src_data   (src_data),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_rd_data (rf_rd_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .pend_mask  (pend_mask),
    .wb_err     (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_count   = 0;
  int miscompares = 0;

  // Model state
  int              m_rr;
  bit [NREG-1:0]   m_pend;
  bit              m_we;
  bit [REG_AW-1:0] m_rd;
  bit [XLEN-1:0]   m_data;
  bit              m_err;
  bit              model_valid = 1'b0;

`ifdef RF_WB_ORPHAN_CHECK_EN
  localparam bit ORPHAN_ON = 1'b1;
`else
  localparam bit ORPHAN_ON = 1'b0;
`endif

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [REG_AW-1:0] rdOf(input int s);
    return src_rd[s*REG_AW +: REG_AW];
  endfunction

  function automatic logic [XLEN-1:0] dataOf(input int s);
    return src_data[s*XLEN +: XLEN];
  endfunction

  // First valid source found scanning upward from the model pointer.
  function automatic int modelGrant();
    int s;
    if (rst_n !== 1'b1) return -1;
    for (int k = 0; k < NUM_SRC; k++) begin
      s = (m_rr + k) % NUM_SRC;
      if (src_valid[s]) return s;
    end
    return -1;
  endfunction

  function automatic bit modelIssueReady();
    if (rst_n !== 1'b1) return 1'b0;
    return (issue_rd == 0) || !m_pend[issue_rd];
  endfunction

  int            mdl_g;
  bit [NREG-1:0] mdl_nxt;

  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      m_rr        = 0;
      m_pend      = '0;
      m_we        = 1'b0;
      m_rd        = '0;
      m_data      = '0;
      m_err       = 1'b0;
      model_valid = 1'b1;
    end else begin
      mdl_g   = modelGrant();
      mdl_nxt = m_pend;
      if (m_we) mdl_nxt[m_rd] = 1'b0;
      if (issue_valid && modelIssueReady() && issue_rd != 0) mdl_nxt[issue_rd] = 1'b1;
      if (ORPHAN_ON && mdl_g >= 0 && rdOf(mdl_g) != 0 && !m_pend[rdOf(mdl_g)]) m_err = 1'b1;
      m_we = (mdl_g >= 0) && (rdOf(mdl_g) != 0);
      if (mdl_g >= 0) begin
        m_rd   = rdOf(mdl_g);
        m_data = dataOf(mdl_g);
        m_rr   = (mdl_g + 1) % NUM_SRC;
      end
      m_pend = mdl_nxt;
    end
  end

  int cmp_g;

  always @(negedge clk) begin
    if (model_valid) begin
      cmp_g = modelGrant();
      checkOutput("src_ready", 64'(src_ready), (cmp_g >= 0) ? 64'(1 << cmp_g) : 64'd0);
      checkOutput("issue_ready", 64'(issue_ready), 64'(modelIssueReady()));
      checkOutput("rf_we", 64'(rf_we), 64'(m_we && (rst_n === 1'b1)));
      checkOutput("rf_rd", 64'(rf_rd), 64'(m_rd));
      checkOutput("rf_rd_data", 64'(rf_rd_data), 64'(m_data));
      checkOutput("pend_mask", 64'(pend_mask), 64'(m_pend));
      checkOutput("wb_err", 64'(wb_err), 64'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setSrc(input int s, input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data);
    src_rd[s*REG_AW +: REG_AW] = rd;
    src_data[s*XLEN +: XLEN]   = data;
  endtask

  task automatic applyStimulus(input logic [NUM_SRC-1:0] v, input logic iv,
                               input logic [REG_AW-1:0] ird);
    src_valid   = v;
    issue_valid = iv;
    issue_rd    = ird;
  endtask

  logic [NUM_SRC-1:0] grant_seq [6];
  logic [REG_AW-1:0]  rd_seq    [3];

  initial begin
    grant_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rd_seq    = '{4'd1, 4'd2, 4'd4};

    rst_n = 1'b0;
    src_valid = '0; src_rd = '0; src_data = '0;
    issue_valid = 1'b0; issue_rd = '0;

    // Reset held for two cycles, then idle
    tick(); tick();
    rst_n = 1'b1;
    applyStimulus(3'b000, 1'b0, 4'd5);
    #1;
    checkOutput("reset_rf_we", 64'(rf_we), 64'd0);
    checkOutput("reset_pend", 64'(pend_mask), 64'h0000);
    checkOutput("reset_issue_ready", 64'(issue_ready), 64'd1);
    checkOutput("reset_wb_err", 64'(wb_err), 64'd0);

    // Single path: issue rd=3, source 1 writes it back
    applyStimulus(3'b000, 1'b1, 4'd3);
    tick();
    applyStimulus(3'b000, 1'b0, 4'd0);
    #1;
    checkOutput("single_pend_set", 64'(pend_mask), 64'h0008);
    setSrc(1, 4'd3, 32'hDEADBEEF);
    applyStimulus(3'b010, 1'b0, 4'd0);
    #1;
    checkOutput("single_grant", 64'(src_ready), 64'b010);
    tick();
    applyStimulus(3'b000, 1'b0, 4'd0);
    #1;
    checkOutput("single_we", 64'(rf_we), 64'd1);
    checkOutput("single_rd", 64'(rf_rd), 64'd3);
    checkOutput("single_data", 64'(rf_rd_data), 64'hDEADBEEF);
    tick();
    checkOutput("single_we_drop", 64'(rf_we), 64'd0);
    checkOutput("single_pend_clr", 64'(pend_mask), 64'h0000);

    // WAW block on rd=7 (pointer is at 2, so source 0 wins via wrap)
    applyStimulus(3'b000, 1'b1, 4'd7);
    tick();
    setSrc(0, 4'd7, 32'h0000_7777);
    applyStimulus(3'b001, 1'b1, 4'd7);
    #1;
    checkOutput("waw_blocked", 64'(issue_ready), 64'd0);
    checkOutput("waw_grant", 64'(src_ready), 64'b001);
    tick();
    applyStimulus(3'b000, 1'b1, 4'd7);
    #1;
    checkOutput("waw_commit_we", 64'(rf_we), 64'd1);
    checkOutput("waw_commit_rd", 64'(rf_rd), 64'd7);
    checkOutput("waw_blocked_commit", 64'(issue_ready), 64'd0);
    applyStimulus(3'b000, 1'b0, 4'd7);
    tick();
    checkOutput("waw_pend_clr", 64'(pend_mask), 64'h0000);
    checkOutput("waw_free", 64'(issue_ready), 64'd1);

    // Set/clear collision on rd=9
    applyStimulus(3'b000, 1'b1, 4'd9);
    tick();
    setSrc(2, 4'd9, 32'h0000_9001);
    applyStimulus(3'b100, 1'b0, 4'd0);
    #1;
    checkOutput("coll_grant", 64'(src_ready), 64'b100);
    tick();
    applyStimulus(3'b000, 1'b0, 4'd0);
    tick();
    checkOutput("coll_first_clear", 64'(pend_mask), 64'h0000);
    setSrc(1, 4'd9, 32'h0000_9002);
    applyStimulus(3'b010, 1'b0, 4'd0);
    tick();
    applyStimulus(3'b000, 1'b1, 4'd9);
    #1;
    checkOutput("coll_commit_we", 64'(rf_we), 64'd1);
    checkOutput("coll_commit_rd", 64'(rf_rd), 64'd9);
    checkOutput("coll_issue_ready", 64'(issue_ready), 64'd1);
    tick();
    applyStimulus(3'b000, 1'b0, 4'd0);
    #1;
    checkOutput("coll_set_wins", 64'(pend_mask), 64'h0200);

    // x0 write: handshaken, no write enable, scoreboard untouched
    setSrc(0, 4'd0, 32'hFFFFFFFF);
    applyStimulus(3'b001, 1'b0, 4'd0);
    #1;
    checkOutput("x0_grant", 64'(src_ready), 64'b001);
    tick();
    applyStimulus(3'b000, 1'b0, 4'd0);
    #1;
    checkOutput("x0_we", 64'(rf_we), 64'd0);
    checkOutput("x0_data", 64'(rf_rd_data), 64'hFFFFFFFF);
    checkOutput("x0_pend", 64'(pend_mask), 64'h0200);

    // Reset arriving while a write sits in the output stage
    setSrc(2, 4'd5, 32'h0000_5555);
    applyStimulus(3'b100, 1'b0, 4'd0);
    tick();
    applyStimulus(3'b000, 1'b0, 4'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_we", 64'(rf_we), 64'd0);
    checkOutput("rst_mid_ready", 64'(issue_ready), 64'd0);
    tick();
    checkOutput("rst_mid_we2", 64'(rf_we), 64'd0);
    checkOutput("rst_mid_pend", 64'(pend_mask), 64'h0000);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_after_we", 64'(rf_we), 64'd0);

    // Orphan write to rd=12
    setSrc(1, 4'd12, 32'h0000_C0C0);
    applyStimulus(3'b010, 1'b0, 4'd0);
    tick();
    applyStimulus(3'b000, 1'b0, 4'd0);
    #1;
    checkOutput("orphan_we", 64'(rf_we), 64'd1);
    checkOutput("orphan_err", 64'(wb_err), 64'(ORPHAN_ON));
    tick(); tick();
    checkOutput("orphan_err_sticky", 64'(wb_err), 64'(ORPHAN_ON));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("orphan_err_reset", 64'(wb_err), 64'd0);

    // Round-robin with all three sources valid every cycle
    setSrc(0, 4'd1, 32'hA000_0000);
    setSrc(1, 4'd2, 32'hA000_0001);
    setSrc(2, 4'd4, 32'hA000_0002);
    applyStimulus(3'b111, 1'b0, 4'd0);
    #1;
    for (int k = 0; k < 6; k++) begin
      checkOutput("rr_grant", 64'(src_ready), 64'(grant_seq[k]));
      tick();
      checkOutput("rr_we", 64'(rf_we), 64'd1);
      checkOutput("rr_rd", 64'(rf_rd), 64'(rd_seq[k % 3]));
    end
    applyStimulus(3'b000, 1'b0, 4'd0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Writeback scheduler for the 16-entry, single-write-port register file (x0 hardwired zero).
- Shares the one write port between NUM_SRC writeback producers (ALU, load unit, CSR/mul) using round-robin arbitration, with a one-stage registered output.
- Keeps a pending-write scoreboard so issue logic can detect RAW and WAW hazards on architectural registers.

Parameters:
NUM_SRC, 3, number of writeback requesters (2..4)
XLEN, 32, data width
REG_AW, 4, register index width (2**REG_AW registers)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
src_valid  in  NUM_SRC  per-source write request
src_ready  out  NUM_SRC  per-source grant/accept
src_rd  in  NUM_SRC*REG_AW  packed destination index; source i at [i*REG_AW +: REG_AW]
src_data  in  NUM_SRC*XLEN  packed write data; source i at [i*XLEN +: XLEN]
rf_we  out  1  register file write enable
rf_rd  out  REG_AW  register file write index
rf_rd_data  out  XLEN  register file write data
issue_valid  in  1  issue stage allocating a destination
issue_rd  in  REG_AW  destination being allocated
issue_ready  out  1  allocation accepted
pend_mask  out  2**REG_AW  bit r set = write to r outstanding
wb_err  out  1  sticky orphan-write flag (see Optional Feature)

Behaviour:
- Reset (rst_n low at posedge): rf_we=0, rf_rd=0, rf_rd_data=0, pend_mask=0, wb_err=0, RR pointer=0. src_ready and issue_ready are forced 0 while rst_n is low. Reset mid-transfer drops any registered write; no write reaches the regfile on the reset cycle or the cycle after.
- Arbitration is combinational in the current cycle:
  - At most one src_ready is high, and only for a source with src_valid high.
  - Priority order starts at the RR pointer and wraps modulo NUM_SRC.
  - With no valid sources, all src_ready are 0.
- Handshake: a transfer occurs when src_valid[i] && src_ready[i]. Sources hold rd/data stable while valid and not ready.
- RR pointer: after a transfer from source i, the pointer becomes (i+1) mod NUM_SRC. It is unchanged in idle cycles.
- Output stage, 1-cycle latency:
  - On a transfer, at the next posedge rf_we=1 if src_rd!=0, else 0. rf_rd and rf_rd_data take the granted values.
  - With no transfer, rf_we=0 next cycle; rf_rd and rf_rd_data hold their last values.
  - Throughput is one write per cycle. The output stage never stalls.
- x0: a write to x0 is still handshaken but never asserts rf_we and never touches the scoreboard.
- Scoreboard:
  - issue_ready = rst_n && (issue_rd==0 || !pend_mask[issue_rd]).
  - An issue with issue_valid && issue_ready && issue_rd!=0 sets pend_mask[issue_rd] at the next posedge.
  - pend_mask[r] clears at the posedge ending a cycle in which rf_we=1 and rf_rd=r, i.e. when the write commits to the regfile.
  - If a clear and a set of the same r coincide, set wins (bit stays 1).
  - issue_ready is computed from the registered pend_mask. A register being cleared this cycle still reads busy, so there is no same-cycle bypass.
- pend_mask[0] is always 0.

Optional Feature:
- Macro: RF_WB_ORPHAN_CHECK_EN.
- When defined: wb_err goes high at the posedge after a transfer whose src_rd!=0 and whose pend_mask[src_rd] was 0 in the transfer cycle. It then stays high until reset. The write itself proceeds normally.
- When undefined: wb_err is tied 0, no check logic is generated, and all other behaviour is identical.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, then release. Required: rf_we=0, pend_mask=16'h0000, issue_ready=1 for issue_rd=5, wb_err=0.
- Single path: issue rd=3. Next cycle pend_mask=16'h0008. Source1 then writes rd=3, data=32'hDEADBEEF. Required: rf_we=1, rf_rd=3, rf_rd_data=32'hDEADBEEF exactly 1 cycle after the handshake; pend_mask=0 the cycle after that.
- Round-robin: all 3 sources hold valid continuously with rd=1, 2, 4. Required: grants 0,1,2,0,1,2 on consecutive cycles and rf_we high every cycle from cycle 1.
- WAW block: rd=7 is pending and issue_rd=7 is presented. Required: issue_ready=0, including the commit cycle itself. issue_ready=1 in the cycle after pend_mask[7] clears.
- Set/clear collision: the rd=9 commit cycle (rf_we=1, rf_rd=9) coincides with issue of rd=9 after a prior clear path. Required: pend_mask[9]=1 afterwards. Also, a write to x0 with data 32'hFFFFFFFF is handshaken and rf_we stays 0.
- Orphan (macro defined): a write to rd=12 with pend_mask[12]=0 sets wb_err=1 next cycle and keeps it high. With the macro undefined, the same stimulus leaves wb_err=0.
